// File: rtl/logic_unit_sequencer_pkg.sv
// Shared encodings for the bit-serial logic unit sequencer and its 1-bit cell.
package logic_unit_sequencer_pkg;

   localparam logic [1:0] OP_NAND = 2'b00;
   localparam logic [1:0] OP_AND  = 2'b01;
   localparam logic [1:0] OP_OR   = 2'b10;
   localparam logic [1:0] OP_XOR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/logic_unit_sequencer_cell.sv
// One-bit two-input logic cell: NAND/AND/OR/XOR chosen by a 2-bit op.
module logic_cell_1b
   import logic_unit_sequencer_pkg::*;
(
   input  logic       x,
   input  logic       y,
   input  logic [1:0] op,
   output logic       z
);

   always_comb begin
      z = 1'b0;
      unique case (op)
         OP_NAND: z = ~(x & y);
         OP_AND:  z = x & y;
         OP_OR:   z = x | y;
         OP_XOR:  z = x ^ y;
         default: z = 1'b0;
      endcase
   end

endmodule

// File: rtl/logic_unit_sequencer.sv
// Bit-serial sequencer: streams WIDTH-bit operands LSB-first through one 1-bit
// logic cell and returns the assembled result over a valid/ready handshake.
module logic_unit_sequencer
   import logic_unit_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [1:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             cell_z;
   logic [WIDTH-1:0] result_shift;

   logic_cell_1b u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .op (op_q),
      .z  (cell_z)
   );

   // New bit enters at the MSB so after WIDTH shifts bit 0 sits at result[0].
   always_comb begin
      result_shift            = result >> 1;
      result_shift[WIDTH-1]   = cell_z;
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         result <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         op_q   <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  op_q  <= op;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               result <= result_shift;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               // Exit at WIDTH-1 rather than incrementing, so cnt never wraps.
               if (cnt == CNT_LAST) begin
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Self-checking bench: table vectors, random ops vs a word-level model, reset
// abort and a WIDTH=1 instance.
module tb_logic_unit_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [1:0] op = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       busy;

   logic       in_valid1 = 1'b0;
   logic       in_ready1;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic [1:0] op1 = '0;
   logic       out_valid1;
   logic       out_ready1 = 1'b1;
   logic [0:0] result1;
   logic       busy1;

   int n_checks = 0;
   int n_fail   = 0;

   logic_unit_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   logic_unit_sequencer #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .op        (op1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .result    (result1),
      .busy      (busy1)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      int         hold;
      bit         compete;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [0:0] a;
      logic [0:0] b;
      logic [1:0] op;
      logic [0:0] exp;
   } vec1_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] o);
      case (o)
         2'd0:    return ~(x & y);
         2'd1:    return x & y;
         2'd2:    return x | y;
         default: return x ^ y;
      endcase
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One full transaction; out_ready is held low for the first `hold` DONE cycles.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                         input int hold, input bit compete, input logic [7:0] expv,
                         input string name);
      int cyc;
      chk({name, " in_ready before"}, in_ready, 1);
      a         = ta;
      b         = tb;
      op        = top;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      step;
      in_valid = compete;
      if (compete) begin
         a  = ~ta;
         b  = ~tb;
         op = ~top;
      end
      chk({name, " busy after accept"}, busy, 1);
      chk({name, " in_ready after accept"}, in_ready, 0);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         step;
         cyc++;
      end
      chk({name, " latency"}, cyc, 8);
      chk({name, " result"}, result, expv);
      for (int i = 0; i < hold; i++) begin
         step;
         chk({name, " held out_valid"}, out_valid, 1);
         chk({name, " held result"}, result, expv);
         chk({name, " held in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step;
      chk({name, " in_ready after exit"}, in_ready, 1);
      chk({name, " out_valid after exit"}, out_valid, 0);
      chk({name, " busy after exit"}, busy, 0);
      chk({name, " result kept"}, result, expv);
   endtask

   vec_t  vecs[5];
   vec1_t vecs1[3];

   initial begin
      vecs[0] = '{8'hF0, 8'hCC, 2'b00, 0, 1'b0, 8'h3F};
      vecs[1] = '{8'hF0, 8'hCC, 2'b01, 0, 1'b0, 8'hC0};
      vecs[2] = '{8'hF0, 8'hCC, 2'b10, 0, 1'b0, 8'hFC};
      vecs[3] = '{8'hF0, 8'hCC, 2'b11, 0, 1'b0, 8'h3C};
      vecs[4] = '{8'hAA, 8'h0F, 2'b11, 5, 1'b1, 8'hA5};
      vecs1[0] = '{1'b1, 1'b1, 2'b00, 1'b0};
      vecs1[1] = '{1'b1, 1'b1, 2'b11, 1'b0};
      vecs1[2] = '{1'b1, 1'b0, 2'b10, 1'b1};

      // Reset held from time 0, checked before any clock edge.
      #3;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset result", result, 0);
      chk("reset w1 in_ready", in_ready1, 1);
      #7 rst = 1'b0;
      step;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, vecs[i].compete,
                vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Abort mid-RUN: accept, then assert reset during RUN cycle 4.
      a        = 8'hF0;
      b        = 8'hCC;
      op       = 2'b01;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      step;
      step;
      chk("abort busy before", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort out_valid", out_valid, 0);
      chk("abort result", result, 0);
      chk("abort busy", busy, 0);
      chk("abort in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step;
      run_op(8'h01, 8'h80, 2'b10, 0, 1'b0, 8'h81, "after abort");

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb;
         logic [1:0] ro;
         ra = 8'($urandom);
         rb = 8'($urandom);
         ro = 2'($urandom_range(0, 3));
         run_op(ra, rb, ro, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                model(ra, rb, ro), $sformatf("rand%0d", i));
      end

      // WIDTH=1 instance: one RUN cycle, then DONE.
      foreach (vecs1[i]) begin
         a1        = vecs1[i].a;
         b1        = vecs1[i].b;
         op1       = vecs1[i].op;
         in_valid1 = 1'b1;
         step;
         in_valid1 = 1'b0;
         chk($sformatf("w1 vec%0d run out_valid", i), out_valid1, 0);
         chk($sformatf("w1 vec%0d run busy", i), busy1, 1);
         step;
         chk($sformatf("w1 vec%0d out_valid", i), out_valid1, 1);
         chk($sformatf("w1 vec%0d result", i), result1, vecs1[i].exp);
         step;
         chk($sformatf("w1 vec%0d in_ready", i), in_ready1, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
